// File: rtl/cdf_pkg.sv
// Shared constants, widths and FSM state type for the CDF write-back stage.
package cdf_pkg;

  localparam logic [15:0] CDF_TAG  = 16'haaaa;
  localparam int          CDF_BINS = 256;
  localparam int          DATA_W   = 20;
  localparam int          ADDR_W   = 16;
  localparam int          BUS_W    = 36;
  localparam int          CNT_W    = 9;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH,
    DONE
  } cdf_state_t;

endpackage

// File: rtl/cdf_wr_fifo.sv
// Small synchronous FIFO whose front entry is held in a dedicated register,
// so consumers see a flop-driven head that only moves on a pop.
module cdf_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic             full,
  output logic             will_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]    count, remain, count_next;
  logic             do_push, do_pop;

  assign full       = (count == FULL_CNT);
  assign do_pop     = pop && (count != '0);
  assign do_push    = push && (!full || do_pop);
  assign remain     = count - CW'(do_pop);
  assign count_next = remain + CW'(do_push);
  assign rd_next    = rd_ptr + PW'(do_pop);
  assign will_empty = (count_next == '0);

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  // Next head is the incoming word when nothing older survives this cycle's pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr     <= rd_next;
      count      <= count_next;
      head_valid <= (count_next != '0);
      if (count_next == '0)  head <= '0;
      else if (remain == '0) head <= din;
      else                   head <= mem[rd_next];
    end
  end

endmodule

// File: rtl/cdf_store.sv
// Write-back of the accumulated CDF stream into tagged histogram memory,
// with a small stall buffer, bin counting and frame completion tracking.
module cdf_store
  import cdf_pkg::*;
#(
  parameter logic [15:0] TAG   = CDF_TAG,
  parameter int          BINS  = CDF_BINS,
  parameter int          DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              done_in,
  input  logic              output_base_offset,
  input  logic              write_grant,
  output logic [BUS_W-1:0]  WriteBus,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic              WriteEnable,
  output logic              busy,
  output logic [DATA_W-1:0] last_value,
  output logic              overflow_err,
  output logic              done
);

  localparam int FIFO_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] BINS_CNT = CNT_W'(BINS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BINS - 1);

  cdf_state_t        state;
  logic [CNT_W-1:0]  write_count, count_next;
  logic [FIFO_W-1:0] head;
  logic              head_valid, full, will_empty;
  logic              push_req, pop, drop, at_max;
  logic              unused_addr_msb;

  assign unused_addr_msb = addr_in[15];
  assign push_req   = valid_in && start && (state == ACTIVE);
  assign pop        = head_valid && write_grant;
  assign drop       = push_req && full && !pop;
  assign at_max     = (write_count == BINS_CNT);
  assign count_next = (pop && !at_max) ? write_count + 1'b1 : write_count;

  // The destination half is latched with the entry, not applied at write time.
  cdf_wr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (!start),
    .push       (push_req),
    .pop        (pop),
    .din        ({output_base_offset, addr_in[14:0], data_in}),
    .head       (head),
    .head_valid (head_valid),
    .full       (full),
    .will_empty (will_empty)
  );

  assign WriteEnable = head_valid;
  assign WriteAddr   = head[FIFO_W-1 -: ADDR_W];
  assign WriteBus    = {head_valid ? TAG : 16'h0000, head[DATA_W-1:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      write_count  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
      last_value   <= '0;
    end else if (!start) begin
      state        <= IDLE;
      write_count  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      // The first commit of a frame clears the previous frame's result.
      if (pop) begin
        write_count <= count_next;
        if (at_max) overflow_err <= 1'b1;
        if (write_count == LAST_CNT) last_value <= head[DATA_W-1:0];
        else if (write_count == '0)  last_value <= '0;
      end
      case (state)
        IDLE: begin
          state <= ACTIVE;
          busy  <= 1'b1;
        end
        ACTIVE: begin
          if (drop) overflow_err <= 1'b1;
          if (done_in || count_next == BINS_CNT) state <= FLUSH;
        end
        FLUSH: begin
          if (valid_in) overflow_err <= 1'b1;
          if (will_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          if (valid_in) overflow_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_store.sv
// Randomised and directed bench for cdf_store against a queue-based
// frame model of the write-back behaviour.
module tb_cdf_store;

  localparam int BINS  = 256;
  localparam int DEPTH = 2;
  localparam int M_IDLE = 0, M_ACTIVE = 1, M_FLUSH = 2, M_DONE = 3;

  typedef struct {
    logic [15:0] addr;
    logic [19:0] data;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset, start, valid_in, done_in, output_base_offset, write_grant;
  logic [19:0] data_in;
  logic [15:0] addr_in;
  logic [35:0] WriteBus;
  logic [15:0] WriteAddr;
  logic        WriteEnable, busy, overflow_err, done;
  logic [19:0] last_value;

  int   n_vec = 0;
  int   n_miss = 0;
  int   dut_writes = 0;
  int   w0;
  ent_t mq[$];
  ent_t m_head;
  int   m_state = M_IDLE;
  int   m_cnt = 0;
  bit   m_err = 1'b0;
  logic [19:0] m_last = '0;

  cdf_store dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .valid_in           (valid_in),
    .data_in            (data_in),
    .addr_in            (addr_in),
    .done_in            (done_in),
    .output_base_offset (output_base_offset),
    .write_grant        (write_grant),
    .WriteBus           (WriteBus),
    .WriteAddr          (WriteAddr),
    .WriteEnable        (WriteEnable),
    .busy               (busy),
    .last_value         (last_value),
    .overflow_err       (overflow_err),
    .done               (done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_state = M_IDLE;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_last  = '0;
  endtask

  // Advance the frame model by one clock using the inputs about to be sampled.
  task automatic modelStep();
    bit   pop;
    ent_t e;
    pop = (mq.size() != 0) && (write_grant === 1'b1);
    if (reset) begin
      modelReset();
      return;
    end
    if (!start) begin
      mq.delete();
      m_state = M_IDLE;
      m_cnt   = 0;
      m_err   = 1'b0;
      return;
    end
    if (pop) begin
      m_head = mq.pop_front();
      if (m_cnt == BINS) m_err = 1'b1;
      else begin
        m_cnt++;
        if (m_cnt == BINS)   m_last = m_head.data;
        else if (m_cnt == 1) m_last = '0;
      end
    end
    case (m_state)
      M_IDLE: m_state = M_ACTIVE;
      M_ACTIVE: begin
        if (valid_in) begin
          if (mq.size() < DEPTH) begin
            e.addr = {output_base_offset, addr_in[14:0]};
            e.data = data_in;
            mq.push_back(e);
          end else m_err = 1'b1;
        end
        if (done_in || m_cnt == BINS) m_state = M_FLUSH;
      end
      M_FLUSH: begin
        if (valid_in) m_err = 1'b1;
        if (mq.size() == 0) m_state = M_DONE;
      end
      default: if (valid_in) m_err = 1'b1;
    endcase
  endtask

  task automatic compareModel();
    logic        we_e;
    logic [35:0] bus_e;
    logic [15:0] addr_e;
    we_e   = (mq.size() != 0);
    bus_e  = '0;
    addr_e = '0;
    if (we_e) begin
      bus_e  = {16'haaaa, mq[0].data};
      addr_e = mq[0].addr;
    end
    checkOutput("WriteEnable", WriteEnable, we_e);
    checkOutput("WriteBus", WriteBus, bus_e);
    checkOutput("WriteAddr", WriteAddr, addr_e);
    checkOutput("busy", busy, (m_state == M_ACTIVE || m_state == M_FLUSH));
    checkOutput("done", done, (m_state == M_DONE));
    checkOutput("overflow_err", overflow_err, m_err);
    checkOutput("last_value", last_value, m_last);
  endtask

  task automatic tick();
    if (WriteEnable && write_grant) dut_writes++;
    modelStep();
    @(posedge clock);
    #1;
    compareModel();
  endtask

  task automatic applyStimulus(input logic v, input logic [19:0] d, input logic [15:0] a, input logic dn);
    valid_in = v;
    data_in  = d;
    addr_in  = a;
    done_in  = dn;
    tick();
  endtask

  initial begin
    int len, sent, guard;
    logic v;
    reset = 1'b1;
    start = 1'b0;
    valid_in = 1'b0;
    done_in = 1'b0;
    data_in = '0;
    addr_in = '0;
    output_base_offset = 1'b0;
    write_grant = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    checkOutput("rst_WriteEnable", WriteEnable, 0);
    checkOutput("rst_WriteBus", WriteBus, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0);

    $display("[TB] nominal frame");
    start = 1'b1;
    output_base_offset = 1'b1;
    write_grant = 1'b1;
    w0 = dut_writes;
    applyStimulus(0, 0, 0, 0);
    checkOutput("nom_busy", busy, 1);
    for (int a = 0; a < 256; a++) begin
      applyStimulus(1'b1, 20'(4 * a), 16'(a), a == 255);
      if (a == 0) begin
        checkOutput("nom_first_we", WriteEnable, 1);
        checkOutput("nom_first_addr", WriteAddr, 16'h8000);
        checkOutput("nom_first_bus", WriteBus, 36'haaaa00000);
      end
    end
    checkOutput("nom_done_early", done, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("nom_done", done, 1);
    checkOutput("nom_last_value", last_value, 20'h003fc);
    checkOutput("nom_overflow", overflow_err, 0);
    checkOutput("nom_writes", dut_writes - w0, 256);
    applyStimulus(1, 20'h12345, 16'h0100, 0);
    checkOutput("excess_overflow", overflow_err, 1);
    checkOutput("excess_done", done, 1);
    start = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_overflow", overflow_err, 0);
    checkOutput("idle_last_hold", last_value, 20'h003fc);

    $display("[TB] short frame");
    start = 1'b1;
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 20'(i + 1), 16'(i), i == 9);
    checkOutput("short_done_early", done, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("short_done", done, 1);
    checkOutput("short_last_value", last_value, 0);

    $display("[TB] stall");
    start = 1'b0;
    applyStimulus(0, 0, 0, 0);
    start = 1'b1;
    output_base_offset = 1'b0;
    write_grant = 1'b0;
    applyStimulus(0, 0, 0, 0);
    w0 = dut_writes;
    applyStimulus(1, 20'h11111, 16'h0001, 0);
    checkOutput("stall_we", WriteEnable, 1);
    checkOutput("stall_bus1", WriteBus, 36'haaaa11111);
    applyStimulus(1, 20'h22222, 16'h0002, 0);
    checkOutput("stall_bus_stable", WriteBus, 36'haaaa11111);
    applyStimulus(1, 20'h33333, 16'h0003, 0);
    checkOutput("stall_overflow", overflow_err, 1);
    checkOutput("stall_bus_stable2", WriteBus, 36'haaaa11111);
    write_grant = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("stall_bus2", WriteBus, 36'haaaa22222);
    applyStimulus(0, 0, 0, 0);
    checkOutput("stall_drained", WriteEnable, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("stall_writes", dut_writes - w0, 2);

    $display("[TB] push and pop while full");
    start = 1'b0;
    applyStimulus(0, 0, 0, 0);
    start = 1'b1;
    applyStimulus(0, 0, 0, 0);
    w0 = dut_writes;
    write_grant = 1'b0;
    applyStimulus(1, 20'h0000a, 16'h000a, 0);
    applyStimulus(1, 20'h0000b, 16'h000b, 0);
    write_grant = 1'b1;
    applyStimulus(1, 20'h0000c, 16'h000c, 0);
    checkOutput("full_overflow", overflow_err, 0);
    checkOutput("full_bus_b", WriteBus, 36'haaaa0000b);
    applyStimulus(0, 0, 0, 0);
    checkOutput("full_bus_c", WriteBus, 36'haaaa0000c);
    applyStimulus(0, 0, 0, 0);
    checkOutput("full_writes", dut_writes - w0, 3);

    $display("[TB] abort");
    start = 1'b0;
    applyStimulus(0, 0, 0, 0);
    start = 1'b1;
    applyStimulus(0, 0, 0, 0);
    w0 = dut_writes;
    for (int i = 0; i <= 100; i++) applyStimulus(1'b1, 20'(i + 20'h40000), 16'(i), 0);
    write_grant = 1'b0;
    applyStimulus(1, 20'h4ffff, 16'h00ff, 0);
    checkOutput("abort_writes_before", dut_writes - w0, 100);
    start = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("abort_we", WriteEnable, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    write_grant = 1'b1;
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("abort_writes_after", dut_writes - w0, 100);

    $display("[TB] asynchronous reset mid-frame");
    start = 1'b1;
    write_grant = 1'b0;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 20'h5a5a5, 16'h0005, 0);
    applyStimulus(1, 20'h6b6b6, 16'h0006, 0);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("areset_we", WriteEnable, 0);
    checkOutput("areset_bus", WriteBus, 0);
    checkOutput("areset_addr", WriteAddr, 0);
    checkOutput("areset_busy", busy, 0);
    checkOutput("areset_last", last_value, 0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    write_grant = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 20'h7c7c7, 16'h0007, 0);
    checkOutput("areset_new_bus", WriteBus, 36'haaaa7c7c7);

    $display("[TB] random frames");
    for (int f = 0; f < 7; f++) begin
      start = 1'b0;
      applyStimulus(0, 0, 0, 0);
      start = 1'b1;
      output_base_offset = 1'($urandom);
      applyStimulus(0, 0, 0, 0);
      len = (f == 6) ? 270 : 1 + int'($urandom_range(39));
      sent = 0;
      guard = 0;
      while (sent < len && guard < 2000) begin
        guard++;
        v = ($urandom_range(3) != 0);
        write_grant = (f == 6) ? 1'b1 : ($urandom_range(3) != 0);
        if (v) sent++;
        applyStimulus(v, 20'($urandom), 16'($urandom), v && sent == len && f != 6);
      end
      for (int k = 0; k < 200 && !done; k++) begin
        write_grant = ($urandom_range(3) != 0);
        applyStimulus(0, 0, 0, 0);
      end
      checkOutput("rand_done", done, 1);
      if ($urandom_range(1) == 1) applyStimulus(1, 20'($urandom), 16'($urandom), 0);
      applyStimulus(0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cdf_store.md
Name: cdf_store

Overview:
- Write-back end of the CDF pipeline. It consumes the 20-bit accumulated CDF stream produced downstream of the fetch stage and writes each value back to the 36-bit tagged histogram memory.
- Memory word format: tag 16'haaaa in [35:20], data in [19:0].
- A 2-entry buffer absorbs memory write stalls.
- It counts the 256 bins and raises done once the last bin is committed.

Parameters:
- TAG, 16'haaaa, valid-word tag written into WriteBus[35:20].
- BINS, 256, number of bins per frame.
- DEPTH, 2, write buffer entries (power of 2, ≥2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  frame enable; held high for the whole frame; low aborts or idles.
- valid_in  in  1  data_in/addr_in qualify this cycle.
- data_in  in  20  accumulated CDF value.
- addr_in  in  16  bin address; bits [14:0] are used.
- done_in  in  1  upstream finished; no further valid_in this frame.
- output_base_offset  in  1  selects the destination half of memory (WriteAddr[15]).
- write_grant  in  1  memory accepts the presented write this cycle.
- WriteBus  out  36  {TAG, data}.
- WriteAddr  out  16  {output_base_offset, addr[14:0]}.
- WriteEnable  out  1  write request; held until granted.
- busy  out  1  state is ACTIVE or FLUSH.
- last_value  out  20  data of the final (BINS-th) committed write.
- overflow_err  out  1  sticky: entry dropped (buffer full or more than BINS writes).
- done  out  1  frame committed.

Behaviour:
Reset:
- All outputs 0, buffer empty, count 0, state IDLE.
- Reset mid-frame discards buffered entries with no write.

Buffer:
- Push when valid_in && state==ACTIVE && (not full || pop).
- Pop when WriteEnable && write_grant.
- Simultaneous push+pop when full is legal: no drop.
- Push while full without pop: entry dropped, overflow_err set.

Output timing:
- WriteEnable, WriteBus and WriteAddr are registered from the buffer head.
- valid_in in cycle N into an empty buffer gives WriteEnable in cycle N+1.
- Sustained throughput is 1 write per cycle with write_grant held high.
- When write_grant=0, the outputs hold stable. Head data must not change while WriteEnable=1 and not granted.

Count (write_count, 9 bits):
- Increments on each pop.
- Saturates at BINS. A pop occurring at BINS is still written, but sets overflow_err.
- last_value is captured on the pop that makes write_count==BINS.

States:
- IDLE: outputs 0, count 0, overflow_err cleared. Goes to ACTIVE when start=1.
- ACTIVE: accept pushes. Goes to FLUSH on done_in, or when write_count reaches BINS. A valid_in coincident with done_in is still pushed.
- FLUSH: no pushes; drain the buffer. Goes to DONE when the buffer is empty and no write is pending.
- DONE: done=1 and busy=0. done stays high while start=1. valid_in is ignored and sets overflow_err.
- Any state with start=0: return to IDLE next cycle. Flush the buffer without writing, clear done and the count. last_value holds until the next frame's first commit.

Other rules:
- done is only asserted in DONE.
- A short frame (done_in before BINS writes) still reaches DONE, with last_value = 0.
- WriteAddr[15] samples output_base_offset at the time of push.

Decomposition:
- Shared package cdf_pkg:
  - CDF_TAG = 16'haaaa
  - CDF_BINS = 256
  - data width 20, address width 16, bus width 36
  - state enum {IDLE, ACTIVE, FLUSH, DONE}
- One sub-module: cdf_wr_fifo.
  - Generic DEPTH-entry synchronous FIFO with push/pop/full/empty and registered head.
  - Carries {addr[15:0], data[19:0]}.
- FSM, counter and tag formation stay in cdf_store.

Test Plan:
1. Nominal frame:
   - Stimulus: reset, start=1, write_grant=1, 256 consecutive valid_in with addr 0..255 and data = 4·addr, base=1, then done_in.
   - Response: 256 writes; WriteAddr = 0x8000+addr; WriteBus = 0xAAAA00000 | 4·addr; done high 2 cycles after the last valid_in; last_value = 0x3FC; overflow_err=0.
2. Stall:
   - Stimulus: write_grant=0 for 3 cycles while 2 values are pushed.
   - Response: WriteEnable=1 with WriteBus stable; a third push sets overflow_err; after the grant returns, exactly 2 writes occur, in order.
3. Push+pop when full:
   - Stimulus: buffer full, write_grant=1, valid_in on the same cycle.
   - Response: no drop; overflow_err=0.
4. Abort:
   - Stimulus: start drops after 100 writes with 2 entries buffered.
   - Response: IDLE next cycle, WriteEnable=0, no further writes, count 0, done=0.
5. Async reset mid-frame:
   - Stimulus: reset asserted between clock edges.
   - Response: all outputs 0 immediately; after release with start=1, the first write uses the new data.
6. Excess and short frames:
   - 257th valid_in: dropped or flagged, overflow_err=1, done still asserted.
   - Short frame of 10 bins plus done_in: done=1, last_value=0.
